exe_stage_pipe: RTL
===================

// Module: exe_stage_pipe
// PURPOSE
//  Execute stage plus EXE/MEM pipeline register for the 5-stage ARM core; sits directly downstream of ID_Stage_Reg.
//  Builds the second operand (val2), runs the ALU and computes the branch target.
//  Holds the NZCV status register and registers results toward the MEM stage.
// PARAMETERS
//  DATA_W      32       datapath width (core is fixed at 32; parameter kept for bench sizing)
//  STATUS_RST  4'b0000  NZCV value loaded on reset
// PORTS
//  clk            in   1   rising-edge clock; sole clock
//  rst            in   1   synchronous, active-high reset
//  freeze         in   1   hold all registers (memory stall)
//  wb_en_in       in   1   write-back enable from ID_Stage_Reg
//  mem_r_en_in    in   1   load
//  mem_w_en_in    in   1   store
//  b_in           in   1   branch
//  s_in           in   1   update status
//  exe_cmd        in   4   ALU command
//  pc_in          in   32  PC+4 of this instruction
//  val_rn         in   32  Rn value
//  val_rm         in   32  Rm value
//  imm            in   1   I bit
//  shift_operand  in   12  shifter operand field
//  signed_imm24   in   24  branch offset (words)
//  dest_in        in   4   destination register
//  branch_taken   out  1   combinational, = b_in
//  branch_addr    out  32  combinational, pc_in + (sext(signed_imm24) << 2)
//  status_out     out  4   registered NZCV {N,Z,C,V}, feeds ID_Stage_Reg status input
//  wb_en_out, mem_r_en_out, mem_w_en_out  out 1 each  registered controls to MEM
//  alu_res_out    out  32  registered ALU result / memory address
//  val_rm_out     out  32  registered store data
//  dest_out       out  4   registered destination
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registered outputs 0, status_out=STATUS_RST. rst overrides freeze.
//  - Latency: 1 cycle; inputs sampled at edge k appear on *_out after edge k.
//  - freeze=1: every register, including status, holds its value. branch_taken/branch_addr stay combinational.
//  - val2 select, priority order:
//    - mem_r_en_in|mem_w_en_in: val2 = zero-extended shift_operand[11:0].
//    - imm=1: val2 = {24'b0, so[7:0]} rotated right by 2*so[11:8].
//    - otherwise: val_rm shifted by so[11:7]; so[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 = pass-through.
//  - exe_cmd:
//    - 0001 MOV v2; 1001 MVN ~v2
//    - 0010 ADD rn+v2; 0011 ADC rn+v2+C
//    - 0100 SUB/CMP rn-v2; 0101 SBC rn-v2-!C
//    - 0110 AND/TST; 0111 ORR; 1000 EOR
//    - any other code: result 0, flags N/Z only.
//  - Flags:
//    - N = res[31]; Z = (res==0).
//    - C: 33-bit carry out for add; NOT borrow for sub.
//    - V: add sets V when operand signs match and the result sign differs; sub sets V when operand signs differ and the result sign differs from rn.
//    - Logic ops and MOV/MVN keep the current C and V.
//  - Status updates at the posedge only when s_in=1, freeze=0 and rst=0. The new value is visible on status_out the next cycle.
//  - Branch: a branch with s_in=0 does not touch status. The ALU result for a branch is don't-care, but it is still registered deterministically.
//  - Arithmetic wraps modulo 2^32. branch_addr wraps modulo 2^32.
// CONFIGURATION
//  EXE_FWD_EN defined:
//    - Adds ports sel_src1 in 2, sel_src2 in 2, alu_res_mem in 32, wb_value in 32.
//    - Operand mux for rn and rm: 00 = port value, 01 = alu_res_mem, 10 = wb_value, 11 = port value.
//    - The forwarded rm also drives val_rm_out (store data).
//  EXE_FWD_EN undefined: ports absent; val_rn/val_rm are used directly.
// TESTING
//  1. rst=1 for 2 cycles with freeze=1 -> all *_out 0, status_out=0000.
//  2. ADD, s=1, rn=32'h7FFFFFFF, imm=1, so=12'h001 -> next cycle alu_res_out=32'h80000000; status_out=1001 (N,V).
//  3. SUB, s=1, rn=5, val_rm=5, so=0 -> alu_res_out=0; status_out=0110 (Z,C).
//     Then ADC, rn=1, imm, so=12'h001 -> alu_res_out=3.
//  4. Imm rotate: MOV imm, so=12'h2FF -> alu_res_out=32'hF000000F.
//     ASR: val_rm=32'h80000000, so={5'd4,2'b10,1'b0,4'h0} -> alu_res_out=32'hF8000000.
//  5. b_in=1, pc_in=32'h100, signed_imm24=24'hFFFFFE -> branch_taken=1, branch_addr=32'hF8 same cycle; status unchanged.
//  6. freeze=1 with an ADD s=1 presented -> outputs and status hold; release -> result appears next cycle.
//     With EXE_FWD_EN: sel_src1=01, alu_res_mem=10 -> rn treated as 10.

Source files
------------

// File: rtl/exe_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exe_stage_pipe
//  Description : Execute stage and EXE/MEM pipeline register. Builds val2,
//                runs the ALU, computes the branch target and holds NZCV.
//                Optional operand forwarding is enabled by macro EXE_FWD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module exe_stage_pipe #(
    parameter int          DATA_W     = 32,
    parameter logic [3:0]  STATUS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       signed_imm24,
    input  logic [3:0]        dest_in,
`ifdef EXE_FWD_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] alu_res_mem,
    input  logic [DATA_W-1:0] wb_value,
`endif
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        dest_out
);

    localparam logic [3:0] c_cmd_mov = 4'b0001;
    localparam logic [3:0] c_cmd_mvn = 4'b1001;
    localparam logic [3:0] c_cmd_add = 4'b0010;
    localparam logic [3:0] c_cmd_adc = 4'b0011;
    localparam logic [3:0] c_cmd_sub = 4'b0100;
    localparam logic [3:0] c_cmd_sbc = 4'b0101;
    localparam logic [3:0] c_cmd_and = 4'b0110;
    localparam logic [3:0] c_cmd_orr = 4'b0111;
    localparam logic [3:0] c_cmd_eor = 4'b1000;

    logic [DATA_W-1:0]   w_rn;
    logic [DATA_W-1:0]   w_rm;
    logic [DATA_W-1:0]   w_val2;
    logic [DATA_W-1:0]   w_res;
    logic [3:0]          w_flags;
    logic [DATA_W:0]     w_add;
    logic [DATA_W:0]     w_adc;
    logic [DATA_W:0]     w_sub;
    logic [DATA_W:0]     w_sbc;
    logic [2*DATA_W-1:0] w_imm_dbl;
    logic [2*DATA_W-1:0] w_rm_dbl;
    logic [DATA_W-1:0]   w_imm8;
    logic [4:0]          w_sh;
    logic [4:0]          w_rot;

    logic [3:0]          r_status;
    logic                r_wb_en;
    logic                r_mem_r_en;
    logic                r_mem_w_en;
    logic [DATA_W-1:0]   r_alu_res;
    logic [DATA_W-1:0]   r_val_rm;
    logic [3:0]          r_dest;

`ifdef EXE_FWD_EN
    always_comb begin
        case (sel_src1)
            2'b01:   w_rn = alu_res_mem;
            2'b10:   w_rn = wb_value;
            default: w_rn = val_rn;
        endcase
        case (sel_src2)
            2'b01:   w_rm = alu_res_mem;
            2'b10:   w_rm = wb_value;
            default: w_rm = val_rm;
        endcase
    end
`else
    assign w_rn = val_rn;
    assign w_rm = val_rm;
`endif

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm24[23]}}, signed_imm24, 2'b00};

    // Rotations use a doubled word so a right shift yields the rotated value.
    assign w_sh      = shift_operand[11:7];
    assign w_rot     = {shift_operand[11:8], 1'b0};
    assign w_imm8    = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    assign w_imm_dbl = {w_imm8, w_imm8} >> w_rot;
    assign w_rm_dbl  = {w_rm, w_rm} >> w_sh;

    always_comb begin
        w_val2 = w_rm;
        if (mem_r_en_in || mem_w_en_in) begin
            w_val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        end else if (imm) begin
            w_val2 = w_imm_dbl[DATA_W-1:0];
        end else begin
            case (shift_operand[6:5])
                2'b00:   w_val2 = w_rm << w_sh;
                2'b01:   w_val2 = w_rm >> w_sh;
                2'b10:   w_val2 = $signed(w_rm) >>> w_sh;
                default: w_val2 = w_rm_dbl[DATA_W-1:0];
            endcase
        end
    end

    // Subtraction carry is NOT borrow, i.e. the inverted top bit of the difference.
    assign w_add = {1'b0, w_rn} + {1'b0, w_val2};
    assign w_adc = w_add + {{DATA_W{1'b0}}, r_status[1]};
    assign w_sub = {1'b0, w_rn} - {1'b0, w_val2};
    assign w_sbc = w_sub - {{DATA_W{1'b0}}, ~r_status[1]};

    always_comb begin
        w_res      = '0;
        w_flags    = r_status;
        case (exe_cmd)
            c_cmd_mov: w_res = w_val2;
            c_cmd_mvn: w_res = ~w_val2;
            c_cmd_and: w_res = w_rn & w_val2;
            c_cmd_orr: w_res = w_rn | w_val2;
            c_cmd_eor: w_res = w_rn ^ w_val2;
            c_cmd_add, c_cmd_adc: begin
                w_res      = (exe_cmd == c_cmd_add) ? w_add[DATA_W-1:0] : w_adc[DATA_W-1:0];
                w_flags[1] = (exe_cmd == c_cmd_add) ? w_add[DATA_W] : w_adc[DATA_W];
                w_flags[0] = (w_rn[DATA_W-1] == w_val2[DATA_W-1]) &&
                             (w_res[DATA_W-1] != w_rn[DATA_W-1]);
            end
            c_cmd_sub, c_cmd_sbc: begin
                w_res      = (exe_cmd == c_cmd_sub) ? w_sub[DATA_W-1:0] : w_sbc[DATA_W-1:0];
                w_flags[1] = (exe_cmd == c_cmd_sub) ? ~w_sub[DATA_W] : ~w_sbc[DATA_W];
                w_flags[0] = (w_rn[DATA_W-1] != w_val2[DATA_W-1]) &&
                             (w_res[DATA_W-1] != w_rn[DATA_W-1]);
            end
            default: w_res = '0;
        endcase
        w_flags[3] = w_res[DATA_W-1];
        w_flags[2] = (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= STATUS_RST;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_alu_res  <= '0;
            r_val_rm   <= '0;
            r_dest     <= 4'd0;
        end else if (!freeze) begin
            r_wb_en    <= wb_en_in;
            r_mem_r_en <= mem_r_en_in;
            r_mem_w_en <= mem_w_en_in;
            r_alu_res  <= w_res;
            r_val_rm   <= w_rm;
            r_dest     <= dest_in;
            if (s_in) begin
                r_status <= w_flags;
            end
        end
    end

    assign status_out   = r_status;
    assign wb_en_out    = r_wb_en;
    assign mem_r_en_out = r_mem_r_en;
    assign mem_w_en_out = r_mem_w_en;
    assign alu_res_out  = r_alu_res;
    assign val_rm_out   = r_val_rm;
    assign dest_out     = r_dest;

endmodule
`default_nettype wire
